pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the fetch stage; it replaces the fixed-increment PC register. It drives the instruction address and the instruction-memory chip enable. It adds:
- configurable reset and exception vectors
- stall hold
- branch/jump redirect, with a one-entry pending-redirect buffer for redirects that arrive during a stall
- exception flush
- optional alignment check on redirect targets

It sits between the control/ID stage, which supplies stall, branch and flush requests, and the instruction ROM/cache.

## Interface
- `ADDR_W`, 32: PC width in bits.
- `RESET_VEC`, 32'h0000_0000: PC value while in reset and on the first enabled cycle.
- `EXC_VEC`, 32'h0000_0020: target taken on misaligned redirect, only when `PC_ALIGN_CHECK_EN` is defined.
- `STEP`, 4: sequential increment in bytes.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `stall` input 1: hold the PC; 1 = stall.
- `br_flag` input 1: redirect request, branch or jump.
- `br_target` input ADDR_W: redirect target, sampled when `br_flag`=1.
- `flush` input 1: exception flush.
- `flush_pc` input ADDR_W: handler address, sampled when `flush`=1.
- `pc` output ADDR_W: current fetch address.
- `ce` output 1: instruction-memory chip enable.
- `misalign` output 1: one-cycle pulse indicating a misaligned redirect was trapped.
- `bad_addr` output ADDR_W: the last trapped misaligned target.

## Operation
FSM states:
- **BOOT**: entered on reset; `ce`=0.
- **RUN**: `ce`=1; PC advances.
- **HOLD**: `ce`=1; PC frozen.

Transitions:
- BOOT→RUN on the first rising edge with `rst`=1. The PC is not updated on that edge and stays `RESET_VEC`.
- In RUN, with `stall`=1 and no flush: →HOLD.
- In HOLD, with `stall`=0 or `flush`=1: →RUN.

Next-PC priority, evaluated in RUN and HOLD:
1. `flush`: PC ← `flush_pc`. The pending buffer is cleared. Stall is ignored.
2. `stall`: PC unchanged. If `br_flag`=1, `br_target` is written into the pending buffer. A later redirect overwrites an earlier one.
3. Pending buffer valid (and no stall): PC ← pending target; the buffer is cleared. A coincident `br_flag` takes precedence over the stale pending entry; the buffer is still cleared.
4. `br_flag`: PC ← `br_target`.
5. Otherwise: PC ← PC + `STEP`, modulo 2^ADDR_W. 32'hFFFF_FFFC wraps to 0.

Other rules:
- In BOOT, all of `stall`, `br_flag` and `flush` are ignored.
- `flush_pc` is never alignment-checked.
- The pending buffer is one valid bit plus ADDR_W bits.

Reset values:
- `pc` = `RESET_VEC`
- `ce` = 0
- `misalign` = 0
- `bad_addr` = 0
- state = BOOT
- pending buffer invalid

## Timing
- Redirect latency is one edge: `br_flag` sampled at edge N gives `pc` = target after edge N.
- Stall is honoured on the same edge it is sampled.
- After a stall releases at edge N, a pending target appears after edge N.
- Reset assertion is asynchronous: the outputs take their reset values immediately, mid-stall or mid-redirect, and all pending state is discarded.
- Reset deassertion: `ce` rises after the first edge. The PC first changes after the second edge.
- `misalign` is registered. It is high for exactly the one cycle following the edge at which the trapping redirect was applied.

## Configuration
- **`PC_ALIGN_CHECK_EN` defined:** a redirect (direct or from the pending buffer) whose target has bits [1:0] ≠ 0 is trapped instead of applied:
  - PC ← `EXC_VEC`
  - `bad_addr` ← the offending target
  - `misalign` pulses
- **Not defined:**
  - targets are applied unchanged
  - `misalign` is tied to 0
  - `bad_addr` is tied to 0
  - `EXC_VEC` is unused

## Test plan
- Reset release, idle inputs, `RESET_VEC`=0 -> `ce` = 0 then 1; `pc` sequence 0, 0, 4, 8, C.
- `br_flag`=1, `br_target`=32'h100 at pc=8 -> next pc 32'h100, then 32'h104.
- `stall` for 3 cycles with `br_flag`/`br_target`=32'h200 pulsed in cycle 2 -> `pc` held; on stall release pc=32'h200.
- `flush`=1, `flush_pc`=32'h80 together with `stall`=1 and a pending redirect -> pc=32'h80; pending discarded (next pc 32'h84); state RUN.
- With `PC_ALIGN_CHECK_EN`: `br_target`=32'h102 -> pc=`EXC_VEC`; `bad_addr`=32'h102; `misalign` high for 1 cycle. Without the macro -> pc=32'h102.
- `rst` asserted mid-stall with a pending target; pc=32'hFFFF_FFFC run unstalled -> immediate pc=`RESET_VEC`, `ce`=0, pending lost; a separate run from 32'hFFFF_FFFC wraps to 0.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch-stage program counter: stall hold, redirect with one-entry pending buffer, flush.
// Define PC_ALIGN_CHECK_EN to trap misaligned redirect targets to EXC_VEC.
module pc_gen #(
    parameter int unsigned         ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]   RESET_VEC = '0,
    parameter logic [ADDR_W-1:0]   EXC_VEC   = ADDR_W'(32'h0000_0020),
    parameter int unsigned         STEP      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              br_flag,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              misalign,
    output logic [ADDR_W-1:0] bad_addr
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_vld_q, pend_vld_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
    logic              redir;
    logic [ADDR_W-1:0] redir_tgt;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_vld_d = pend_vld_q;
        pend_tgt_d = pend_tgt_q;
        redir      = 1'b0;
        redir_tgt  = br_target;
        unique case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN, S_HOLD: begin
                if (flush) begin
                    pc_d       = flush_pc;
                    pend_vld_d = 1'b0;
                    state_d    = S_RUN;
                end else if (stall) begin
                    state_d = S_HOLD;
                    if (br_flag) begin
                        pend_vld_d = 1'b1;
                        pend_tgt_d = br_target;
                    end
                end else begin
                    state_d    = S_RUN;
                    pend_vld_d = 1'b0;
                    // A fresh redirect supersedes the stale buffered one.
                    if (br_flag || pend_vld_q) begin
                        redir     = 1'b1;
                        redir_tgt = br_flag ? br_target : pend_tgt_q;
                    end else begin
                        pc_d = pc_q + ADDR_W'(STEP);
                    end
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    logic              mis_q, mis_d;
    logic [ADDR_W-1:0] bad_q, bad_d;
    logic [ADDR_W-1:0] pc_fin;

    always_comb begin
        mis_d  = 1'b0;
        bad_d  = bad_q;
        pc_fin = pc_d;
        if (redir) begin
            if (redir_tgt[1:0] != 2'b00) begin
                pc_fin = EXC_VEC;
                bad_d  = redir_tgt;
                mis_d  = 1'b1;
            end else begin
                pc_fin = redir_tgt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mis_q <= 1'b0;
            bad_q <= '0;
        end else begin
            mis_q <= mis_d;
            bad_q <= bad_d;
        end
    end

    assign misalign = mis_q;
    assign bad_addr = bad_q;
`else
    logic [ADDR_W-1:0] pc_fin;
    logic              unused_exc;

    always_comb begin
        pc_fin = pc_d;
        if (redir) begin
            pc_fin = redir_tgt;
        end
    end

    assign unused_exc = ^EXC_VEC;
    assign misalign   = 1'b0;
    assign bad_addr   = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_VEC;
            pend_vld_q <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_fin;
            pend_vld_q <= pend_vld_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign pc = pc_q;
    assign ce = (state_q != S_BOOT);

endmodule

// File: tb/tb_pc_gen.sv
// Directed table-driven bench for pc_gen plus hand-written reset and wrap sequences.
// Expectations follow the PC_ALIGN_CHECK_EN setting of the build.
module tb_pc_gen;

    localparam logic [31:0] EXC = 32'h0000_0020;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        br_flag = 1'b0;
    logic [31:0] br_target = '0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic [31:0] pc;
    logic        ce;
    logic        misalign;
    logic [31:0] bad_addr;

    int checks = 0;
    int failures = 0;

    pc_gen dut (
        .clk(clk), .rst(rst), .stall(stall),
        .br_flag(br_flag), .br_target(br_target),
        .flush(flush), .flush_pc(flush_pc),
        .pc(pc), .ce(ce), .misalign(misalign), .bad_addr(bad_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        br;
        logic [31:0] tgt;
        logic        fl;
        logic [31:0] fpc;
        logic [31:0] e_pc;
        logic        e_ce;
        logic        e_mis;
        logic [31:0] e_bad;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic br,
                         input logic [31:0] tgt, input logic fl,
                         input logic [31:0] fpc);
        stall = st; br_flag = br; br_target = tgt;
        flush = fl; flush_pc = fpc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t v[$];
    logic [31:0] m_pc0, m_pc1, m_bad;
    logic        m_mis;

    initial begin
`ifdef PC_ALIGN_CHECK_EN
        m_pc0 = EXC; m_pc1 = EXC + 32'd4; m_mis = 1'b1; m_bad = 32'h102;
`else
        m_pc0 = 32'h102; m_pc1 = 32'h106; m_mis = 1'b0; m_bad = 32'h0;
`endif
        //         st    br    tgt        fl    fpc        pc         ce    mis    bad
        v.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,     1'b1, 1'b0,  32'h0});
        v.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h4,     1'b1, 1'b0,  32'h0});
        v.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h8,     1'b1, 1'b0,  32'h0});
        v.push_back('{1'b0, 1'b1, 32'h100, 1'b0, 32'h0,   32'h100,   1'b1, 1'b0,  32'h0});
        v.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h104,   1'b1, 1'b0,  32'h0});
        v.push_back('{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h104,   1'b1, 1'b0,  32'h0});
        v.push_back('{1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   32'h104,   1'b1, 1'b0,  32'h0});
        v.push_back('{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h104,   1'b1, 1'b0,  32'h0});
        v.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h200,   1'b1, 1'b0,  32'h0});
        v.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h204,   1'b1, 1'b0,  32'h0});
        v.push_back('{1'b1, 1'b1, 32'h300, 1'b0, 32'h0,   32'h204,   1'b1, 1'b0,  32'h0});
        v.push_back('{1'b1, 1'b0, 32'h0,   1'b1, 32'h80,  32'h80,    1'b1, 1'b0,  32'h0});
        v.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h84,    1'b1, 1'b0,  32'h0});
        v.push_back('{1'b1, 1'b1, 32'h400, 1'b0, 32'h0,   32'h84,    1'b1, 1'b0,  32'h0});
        v.push_back('{1'b0, 1'b1, 32'h500, 1'b0, 32'h0,   32'h500,   1'b1, 1'b0,  32'h0});
        v.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h504,   1'b1, 1'b0,  32'h0});
        v.push_back('{1'b1, 1'b1, 32'h600, 1'b0, 32'h0,   32'h504,   1'b1, 1'b0,  32'h0});
        v.push_back('{1'b1, 1'b1, 32'h700, 1'b0, 32'h0,   32'h504,   1'b1, 1'b0,  32'h0});
        v.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h700,   1'b1, 1'b0,  32'h0});
        v.push_back('{1'b0, 1'b1, 32'h102, 1'b0, 32'h0,   m_pc0,     1'b1, m_mis, m_bad});
        v.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   m_pc1,     1'b1, 1'b0,  m_bad});
        v.push_back('{1'b0, 1'b0, 32'h0,   1'b1, 32'h3,   32'h3,     1'b1, 1'b0,  m_bad});
        v.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h7,     1'b1, 1'b0,  m_bad});

        #12;
        chk("rst_pc", pc, 32'h0);
        chk("rst_ce", {31'b0, ce}, 32'h0);
        chk("rst_mis", {31'b0, misalign}, 32'h0);
        chk("rst_bad", bad_addr, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < v.size(); i++) begin
            drive(v[i].st, v[i].br, v[i].tgt, v[i].fl, v[i].fpc);
            step();
            chk($sformatf("v%0d_pc", i), pc, v[i].e_pc);
            chk($sformatf("v%0d_ce", i), {31'b0, ce}, {31'b0, v[i].e_ce});
            chk($sformatf("v%0d_mis", i), {31'b0, misalign},
                {31'b0, v[i].e_mis});
            chk($sformatf("v%0d_bad", i), bad_addr, v[i].e_bad);
        end

        // Wrap at the top of the address space.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8);
        step();
        chk("wrap_a", pc, 32'hFFFF_FFF8);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        chk("wrap_b", pc, 32'hFFFF_FFFC);
        step();
        chk("wrap_c", pc, 32'h0);

        // Async reset mid-stall with a pending target.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        step();
        chk("pre_rst_pc", pc, 32'hFFFF_FFFC);
        drive(1'b1, 1'b1, 32'h900, 1'b0, 32'h0);
        step();
        chk("hold_pc", pc, 32'hFFFF_FFFC);
        #2;
        rst = 1'b0;
        #1;
        chk("async_pc", pc, 32'h0);
        chk("async_ce", {31'b0, ce}, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        chk("in_rst_pc", pc, 32'h0);
        chk("in_rst_ce", {31'b0, ce}, 32'h0);
        rst = 1'b1;
        step();
        chk("boot_pc", pc, 32'h0);
        chk("boot_ce", {31'b0, ce}, 32'h1);
        step();
        chk("no_pend_pc", pc, 32'h4);
        step();
        chk("seq_pc", pc, 32'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
